bcd_stopwatch_timer_core: RTL and testbench

//  Parametrised BCD stopwatch/countdown core: N-digit counter, internal tick prescaler, start/stop and

---
 rtl/bcd_stopwatch_timer_core_pkg.sv | 23 ++
 rtl/bcd_stopwatch_timer_core_if.sv | 28 ++
 rtl/bcd_stopwatch_timer_core_digit_cell.sv | 29 ++
 rtl/bcd_stopwatch_timer_core.sv | 172 +++++++++++++++++
 tb/tb_bcd_stopwatch_timer_core.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_stopwatch_timer_core_pkg.sv
// Shared types and helpers for the BCD stopwatch/countdown core.
// State encoding, mode codes and the switch-digit clamp.
package bcd_sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UP0  = 2'b00;
    localparam logic [1:0] MODE_UPLD = 2'b01;
    localparam logic [1:0] MODE_DN9  = 2'b10;
    localparam logic [1:0] MODE_DNLD = 2'b11;

    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_timer_core_if.sv
// Button/switch/display bundle between board controls and the stopwatch core.
// BCD_STOPWATCH_LAP_EN adds the lap button and lap_active indicator.
interface bcd_stopwatch_timer_core_if #(
    parameter int DIGITS      = 4,
    parameter int LOAD_DIGITS = 2
);
    logic [1:0]               mode;
    logic                     startstop;
    logic                     resetload;
    logic [4*LOAD_DIGITS-1:0] switch;
    logic [4*DIGITS-1:0]      count;
    logic                     running;
    logic                     done;
`ifdef BCD_STOPWATCH_LAP_EN
    logic                     lap;
    logic                     lap_active;

    modport master (output mode, startstop, resetload, switch, lap,
                    input  count, running, done, lap_active);
    modport slave  (input  mode, startstop, resetload, switch, lap,
                    output count, running, done, lap_active);
`else
    modport master (output mode, startstop, resetload, switch,
                    input  count, running, done);
    modport slave  (input  mode, startstop, resetload, switch,
                    output count, running, done);
`endif
endinterface

// File: rtl/bcd_stopwatch_timer_core_digit_cell.sv
// One BCD digit of the ripple counter: load, increment or decrement on en.
// cout is high when this digit wraps, enabling the next digit up.
module bcd_digit_cell
    import bcd_sw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       cout
);

    assign cout = en & (up ? (digit == BCD_NINE) : (digit == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (en) begin
            if (up) digit <= (digit == BCD_NINE) ? 4'd0 : digit + 4'd1;
            else    digit <= (digit == 4'd0) ? BCD_NINE : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_timer_core.sv
// BCD stopwatch/countdown top: button edge detect, run FSM, tick prescaler, load mux.
// Optional lap freeze display when BCD_STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_timer_core
    import bcd_sw_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int LOAD_DIGITS = 2,
    parameter int TICK_DIV    = 1000000
) (
    input logic                      clk,
    input logic                      rst,
    bcd_stopwatch_timer_core_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam int LSB_LD = DIGITS - LOAD_DIGITS;

    logic                ss_q, ss_qq, rl_q, rl_qq;
    logic                ss_edge, rl_edge;
    state_t              state;
    logic [1:0]          mode_q;
    logic [PW-1:0]       presc;
    logic                running_q, done_q;
    logic                tick, step, count_up, at_term, next_term, enter_done;
    logic                load_nine, load_sw;
    logic [DIGITS-1:0]   en_c, cout_c;
    logic [4*DIGITS-1:0] live_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q  <= 1'b0;
            ss_qq <= 1'b0;
            rl_q  <= 1'b0;
            rl_qq <= 1'b0;
        end else begin
            ss_q  <= bus.startstop;
            ss_qq <= ss_q;
            rl_q  <= bus.resetload;
            rl_qq <= rl_q;
        end
    end

    assign ss_edge   = ss_q & ~ss_qq;
    assign rl_edge   = rl_q & ~rl_qq;
    assign count_up  = (mode_q == MODE_UP0) || (mode_q == MODE_UPLD);
    assign tick      = (presc == TICK_LAST);
    assign step      = (state == RUN) && tick && !rl_edge;
    assign load_nine = (bus.mode == MODE_DN9);
    assign load_sw   = (bus.mode == MODE_UPLD) || (bus.mode == MODE_DNLD);

    // at_term: already at the end value; next_term: the next step lands on it
    always_comb begin
        logic [3:0] d;
        d         = 4'd0;
        at_term   = 1'b1;
        next_term = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = live_count[4*i +: 4];
            if (count_up) begin
                if (d != BCD_NINE) at_term = 1'b0;
                if ((i == 0) ? (d != 4'd8) : (d != BCD_NINE)) next_term = 1'b0;
            end else begin
                if (d != 4'd0) at_term = 1'b0;
                if ((i == 0) ? (d != 4'd1) : (d != 4'd0)) next_term = 1'b0;
            end
        end
    end

    // A carry out of the top digit would mean a wrap, which also ends the run
    assign enter_done = !rl_edge &&
                        (((state == IDLE) && ss_edge && at_term) ||
                         (step && (next_term || cout_c[DIGITS-1])));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_UP0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (rl_edge) begin
            state     <= IDLE;
            mode_q    <= bus.mode;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (enter_done) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            case (state)
                IDLE:    if (ss_edge) begin state <= RUN;   running_q <= 1'b1; end
                RUN:     if (ss_edge) begin state <= PAUSE; running_q <= 1'b0; end
                PAUSE:   if (ss_edge) begin state <= RUN;   running_q <= 1'b1; end
                default: ;
            endcase
        end
    end

    // Prescaler only advances in RUN, so a pause keeps the partial interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                presc <= '0;
        else if (rl_edge)       presc <= '0;
        else if (state == RUN)  presc <= tick ? '0 : presc + PW'(1);
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] ld_val;
        logic [3:0] digit;

        if (i >= LSB_LD) begin : g_sw
            assign ld_val = load_sw ? clamp9(bus.switch[4*(i-LSB_LD) +: 4])
                                    : (load_nine ? BCD_NINE : 4'd0);
        end else begin : g_zero
            assign ld_val = load_nine ? BCD_NINE : 4'd0;
        end

        if (i == 0) begin : g_lsd
            assign en_c[i] = step;
        end else begin : g_rip
            assign en_c[i] = cout_c[i-1];
        end

        bcd_digit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (en_c[i]),
            .up       (count_up),
            .load     (rl_edge),
            .load_val (ld_val),
            .digit    (digit),
            .cout     (cout_c[i])
        );

        assign live_count[4*i +: 4] = digit;
    end

    assign bus.running = running_q;
    assign bus.done    = done_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic                lap_q, lap_qq, lap_edge, lap_on;
    logic [4*DIGITS-1:0] lap_count;

    assign lap_edge = lap_q & ~lap_qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q  <= 1'b0;
            lap_qq <= 1'b0;
            lap_on <= 1'b0;
        end else begin
            lap_q  <= bus.lap;
            lap_qq <= lap_q;
            if (rl_edge || enter_done)
                lap_on <= 1'b0;
            else if (lap_edge && ((state == RUN) || (state == PAUSE)))
                lap_on <= ~lap_on;
        end
    end

    always_ff @(posedge clk) begin
        if (lap_edge && !lap_on) lap_count <= live_count;
    end

    assign bus.lap_active = lap_on;
    assign bus.count      = lap_on ? lap_count : live_count;
`else
    assign bus.count = live_count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_timer_core.sv
// Self-checking bench for bcd_stopwatch_timer_core (DIGITS=4, LOAD_DIGITS=2, TICK_DIV=4).
// Lap sequence is included when BCD_STOPWATCH_LAP_EN is defined.
module tb_bcd_stopwatch_timer_core;

    localparam int DIGITS      = 4;
    localparam int LOAD_DIGITS = 2;
    localparam int TICK_DIV    = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_stopwatch_timer_core_if #(.DIGITS(DIGITS), .LOAD_DIGITS(LOAD_DIGITS)) bus ();

    bcd_stopwatch_timer_core #(
        .DIGITS      (DIGITS),
        .LOAD_DIGITS (LOAD_DIGITS),
        .TICK_DIV    (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  sw;
        logic [15:0] exp_count;
        logic        exp_done;
    } vec_t;

    vec_t        vecs [9];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [15:0] exp_q [$];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic pop_check(input string nm, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: got 0x%0h, expected value missing from queue", nm, act);
        end else begin
            check(nm, act, {16'h0, exp_q.pop_front()});
        end
    endtask

    task automatic pulse_ss();
        bus.startstop = 1'b1;
        step();
        bus.startstop = 1'b0;
    endtask

    task automatic pulse_rl();
        bus.resetload = 1'b1;
        step();
        bus.resetload = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] m, input logic [7:0] sw);
        bus.mode   = m;
        bus.switch = sw;
        pulse_rl();
        step_n(2);
    endtask

    task automatic wait_running(input logic want, input string nm);
        int k = 0;
        while (bus.running !== want && k < 8) begin
            step();
            k++;
        end
        check(nm, {31'h0, bus.running}, {31'h0, want});
    endtask

    task automatic start_run(input string nm);
        pulse_ss();
        wait_running(1'b1, nm);
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p, rem;
        logic [15:0] held;

        vecs[0] = '{2'b00, 8'h12, 16'h0000, 1'b0};
        vecs[1] = '{2'b01, 8'h45, 16'h4500, 1'b0};
        vecs[2] = '{2'b10, 8'h12, 16'h9999, 1'b0};
        vecs[3] = '{2'b11, 8'h37, 16'h3700, 1'b0};
        vecs[4] = '{2'b11, 8'hF3, 16'h9300, 1'b0};
        vecs[5] = '{2'b01, 8'h3C, 16'h3900, 1'b0};
        vecs[6] = '{2'b11, 8'h00, 16'h0000, 1'b1};
        vecs[7] = '{2'b01, 8'h99, 16'h9900, 1'b0};
        vecs[8] = '{2'b10, 8'h00, 16'h9999, 1'b0};

        rst           = 1'b1;
        bus.mode      = 2'b00;
        bus.startstop = 1'b0;
        bus.resetload = 1'b0;
        bus.switch    = 8'h00;
`ifdef BCD_STOPWATCH_LAP_EN
        bus.lap       = 1'b0;
`endif
        step_n(3);
        check("reset count", {16'h0, bus.count}, 32'h0);
        check("reset flags", {30'h0, bus.running, bus.done}, 32'h0);
        rst = 1'b0;
        step_n(2);

        // Table: load per mode/switch, then start from IDLE
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vecs[i].exp_count);
            do_load(vecs[i].mode, vecs[i].sw);
            pop_check($sformatf("vec%0d load count", i), {16'h0, bus.count});
            check($sformatf("vec%0d idle flags", i), {30'h0, bus.running, bus.done}, 32'h0);
            exp_q.push_back(vecs[i].exp_count);
            pulse_ss();
            for (int k = 0; k < 8 && !(bus.running || bus.done); k++) step();
            check($sformatf("vec%0d start flags", i), {30'h0, bus.running, bus.done},
                  {30'h0, !vecs[i].exp_done, vecs[i].exp_done});
            pop_check($sformatf("vec%0d start count", i), {16'h0, bus.count});
        end

        // Up from zero, one step every TICK_DIV cycles after RUN entry
        do_load(2'b00, 8'h00);
        start_run("t1 start");
        run_to(39);
        check("t1 count@39", {16'h0, bus.count}, 32'h0009);
        run_to(40);
        check("t1 count@40", {16'h0, bus.count}, 32'h0010);
        check("t1 running", {31'h0, bus.running}, 32'h1);

        // Pause partway, then resume: only the remaining interval elapses
        run_to(42);
        pulse_ss();
        wait_running(1'b0, "t2 pause");
        p = cyc;
        exp_q.push_back(to_bcd(p / TICK_DIV));
        pop_check("t2 pause count", {16'h0, bus.count});
        held = bus.count;
        step_n(10);
        check("t2 paused hold", {16'h0, bus.count}, {16'h0, held});
        start_run("t2 resume");
        rem = TICK_DIV - (p % TICK_DIV);
        run_to(rem - 1);
        check("t2 before step", {16'h0, bus.count}, {16'h0, to_bcd(p / TICK_DIV)});
        run_to(rem);
        check("t2 after step", {16'h0, bus.count}, {16'h0, to_bcd(p / TICK_DIV + 1)});

        // Down from load, then countdown to zero saturates in DONE
        do_load(2'b11, 8'h88);
        check("t3 load 8800", {16'h0, bus.count}, 32'h8800);
        start_run("t3 start");
        run_to(3);
        check("t3 count@3", {16'h0, bus.count}, 32'h8800);
        run_to(4);
        check("t3 count@4", {16'h0, bus.count}, 32'h8799);
        do_load(2'b11, 8'h01);
        start_run("t3b start");
        run_to(399);
        check("t3b count@399", {16'h0, bus.count}, 32'h0001);
        run_to(400);
        check("t3b count@400", {16'h0, bus.count}, 32'h0000);
        check("t3b done flags", {30'h0, bus.running, bus.done}, 32'h1);
        step_n(20);
        check("t3b hold zero", {16'h0, bus.count}, 32'h0000);
        pulse_ss();
        step_n(3);
        check("t3b ss ignored", {30'h0, bus.running, bus.done}, 32'h1);

        // Up from load saturates at all nines
        do_load(2'b01, 8'h99);
        start_run("t4 start");
        run_to(395);
        check("t4 count@395", {16'h0, bus.count}, 32'h9998);
        run_to(396);
        check("t4 count@396", {16'h0, bus.count}, 32'h9999);
        check("t4 done flags", {30'h0, bus.running, bus.done}, 32'h1);
        step_n(12);
        check("t4 hold nines", {16'h0, bus.count}, 32'h9999);

        // Clamped load, then simultaneous startstop/resetload
        do_load(2'b11, 8'hF3);
        check("t5 load 9300", {16'h0, bus.count}, 32'h9300);
        start_run("t5 start");
        run_to(8);
        check("t5 count@8", {16'h0, bus.count}, 32'h9298);
        bus.startstop = 1'b1;
        bus.resetload = 1'b1;
        step();
        bus.startstop = 1'b0;
        bus.resetload = 1'b0;
        step_n(2);
        check("t5 both flags", {30'h0, bus.running, bus.done}, 32'h0);
        check("t5 reload", {16'h0, bus.count}, 32'h9300);
        step_n(10);
        check("t5 stays idle", {16'h0, bus.count}, 32'h9300);

        // Asynchronous reset in the middle of a run
        do_load(2'b00, 8'h00);
        start_run("t6 start");
        run_to(492);
        check("t6 count@492", {16'h0, bus.count}, 32'h0123);
        #2;
        rst = 1'b1;
        #1;
        check("t6 async count", {16'h0, bus.count}, 32'h0000);
        check("t6 async flags", {30'h0, bus.running, bus.done}, 32'h0);
        step();
        rst = 1'b0;
        step_n(2);

`ifdef BCD_STOPWATCH_LAP_EN
        begin
            int f, g;
            logic [15:0] frozen;
            do_load(2'b00, 8'h00);
            start_run("lap start");
            run_to(20);
            bus.lap = 1'b1;
            step();
            bus.lap = 1'b0;
            for (int k = 0; k < 8 && !bus.lap_active; k++) step();
            check("lap active", {31'h0, bus.lap_active}, 32'h1);
            f = cyc;
            frozen = to_bcd((f - 1) / TICK_DIV);
            check("lap frozen value", {16'h0, frozen}, 32'h0005);
            check("lap freeze 0", {16'h0, bus.count}, {16'h0, frozen});
            for (int k = 1; k < 11; k++) begin
                step();
                check($sformatf("lap freeze %0d", k), {16'h0, bus.count}, {16'h0, frozen});
            end
            bus.lap = 1'b1;
            step();
            bus.lap = 1'b0;
            check("lap freeze 11", {16'h0, bus.count}, {16'h0, frozen});
            for (int k = 0; k < 8 && bus.lap_active; k++) step();
            g = cyc;
            check("lap cleared", {31'h0, bus.lap_active}, 32'h0);
            check("lap live", {16'h0, bus.count}, {16'h0, to_bcd(g / TICK_DIV)});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
